// File: rtl/layer_memory_controller_if.sv
// Bank-access bus of layer_memory_controller: PS input-bank writes, per-layer bank ports
// and registered read data. The host side uses master and the controller uses slave.
interface layer_memory_controller_if #(
    parameter int unsigned IN_WIDTH   = 19,
    parameter int unsigned IN_DEPTH   = 242101,
    parameter int unsigned FEAT_WIDTH = 32,
    parameter int unsigned FEAT_DEPTH = 43328,
    parameter int unsigned SCR_WIDTH  = 201,
    parameter int unsigned SCR_DEPTH  = 13264,
    parameter int unsigned NUM_LAYERS = 2
);
    localparam int unsigned IN_ADDR_W   = $clog2(IN_DEPTH);
    localparam int unsigned FEAT_ADDR_W = $clog2(FEAT_DEPTH);
    localparam int unsigned SCR_ADDR_W  = $clog2(SCR_DEPTH);

    logic                               ps_wr_en;
    logic [IN_ADDR_W-1:0]               ps_wr_addr;
    logic [IN_WIDTH-1:0]                ps_wr_data;

    logic [NUM_LAYERS*IN_ADDR_W-1:0]    lyr_rd_in_addr;
    logic [NUM_LAYERS-1:0]              lyr_feat_wr_en;
    logic [NUM_LAYERS*FEAT_ADDR_W-1:0]  lyr_feat_wr_addr;
    logic [NUM_LAYERS*FEAT_WIDTH-1:0]   lyr_feat_wr_data;
    logic [NUM_LAYERS*FEAT_ADDR_W-1:0]  lyr_feat_rd_addr;
    logic [NUM_LAYERS-1:0]              lyr_scr_wr_en;
    logic [NUM_LAYERS*SCR_ADDR_W-1:0]   lyr_scr_wr_addr;
    logic [NUM_LAYERS*SCR_WIDTH-1:0]    lyr_scr_wr_data;
    logic [NUM_LAYERS*SCR_ADDR_W-1:0]   lyr_scr_rd_addr;
    logic [NUM_LAYERS-1:0]              lyr_done;

    logic [IN_WIDTH-1:0]                in_rd_data;
    logic [FEAT_WIDTH-1:0]              feat_rd_data;
    logic [SCR_WIDTH-1:0]               scr_rd_data;

    modport master (
        output ps_wr_en, ps_wr_addr, ps_wr_data,
        output lyr_rd_in_addr, lyr_feat_wr_en, lyr_feat_wr_addr, lyr_feat_wr_data,
        output lyr_feat_rd_addr, lyr_scr_wr_en, lyr_scr_wr_addr, lyr_scr_wr_data,
        output lyr_scr_rd_addr, lyr_done,
        input  in_rd_data, feat_rd_data, scr_rd_data
    );

    modport slave (
        input  ps_wr_en, ps_wr_addr, ps_wr_data,
        input  lyr_rd_in_addr, lyr_feat_wr_en, lyr_feat_wr_addr, lyr_feat_wr_data,
        input  lyr_feat_rd_addr, lyr_scr_wr_en, lyr_scr_wr_addr, lyr_scr_wr_data,
        input  lyr_scr_rd_addr, lyr_done,
        output in_rd_data, feat_rd_data, scr_rd_data
    );
endinterface

// File: rtl/layer_memory_controller.sv
// Sequences NUM_LAYERS GAT layers over a PS-loaded input bank, ping-pong feature banks and a
// shared scratch bank. Define LMC_SCR_FWD_EN to forward same-address scratch writes to reads.
module layer_memory_controller #(
    parameter int unsigned IN_WIDTH    = 19,
    parameter int unsigned IN_DEPTH    = 242101,
    parameter int unsigned FEAT_WIDTH  = 32,
    parameter int unsigned FEAT_DEPTH  = 43328,
    parameter int unsigned SCR_WIDTH   = 201,
    parameter int unsigned SCR_DEPTH   = 13264,
    parameter int unsigned NUM_LAYERS  = 2,
    localparam int unsigned IN_ADDR_W   = $clog2(IN_DEPTH),
    localparam int unsigned FEAT_ADDR_W = $clog2(FEAT_DEPTH),
    localparam int unsigned SCR_ADDR_W  = $clog2(SCR_DEPTH),
    localparam int unsigned LW          = $clog2(NUM_LAYERS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    ps_load_done,
    layer_memory_controller_if.slave bus,
    output logic [LW-1:0]           cur_layer,
    output logic                    layer_start,
    output logic                    busy,
    output logic                    all_done,
    output logic                    illegal_wr
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [LW-1:0]          cur_layer_q, cur_layer_d;
    logic                   layer_start_q, layer_start_d;
    logic                   busy_q, busy_d;
    logic                   all_done_q, all_done_d;
    logic                   illegal_q, illegal_d;
    logic [IN_WIDTH-1:0]    in_rd_q, in_rd_d;
    logic [FEAT_WIDTH-1:0]  feat_rd_q, feat_rd_d;
    logic [SCR_WIDTH-1:0]   scr_rd_q, scr_rd_d;

    logic [IN_WIDTH-1:0]    in_mem    [IN_DEPTH];
    logic [FEAT_WIDTH-1:0]  feat_mem0 [FEAT_DEPTH];
    logic [FEAT_WIDTH-1:0]  feat_mem1 [FEAT_DEPTH];
    logic [SCR_WIDTH-1:0]   scr_mem   [SCR_DEPTH];

    // Active-layer slice of each per-layer bus
    logic [IN_ADDR_W-1:0]   sel_in_rd_addr;
    logic                   sel_feat_wr_en;
    logic [FEAT_ADDR_W-1:0] sel_feat_wr_addr;
    logic [FEAT_WIDTH-1:0]  sel_feat_wr_data;
    logic [FEAT_ADDR_W-1:0] sel_feat_rd_addr;
    logic                   sel_scr_wr_en;
    logic [SCR_ADDR_W-1:0]  sel_scr_wr_addr;
    logic [SCR_WIDTH-1:0]   sel_scr_wr_data;
    logic [SCR_ADDR_W-1:0]  sel_scr_rd_addr;
    logic                   sel_done;
    logic                   other_wr;

    always_comb begin
        sel_in_rd_addr   = '0;
        sel_feat_wr_en   = 1'b0;
        sel_feat_wr_addr = '0;
        sel_feat_wr_data = '0;
        sel_feat_rd_addr = '0;
        sel_scr_wr_en    = 1'b0;
        sel_scr_wr_addr  = '0;
        sel_scr_wr_data  = '0;
        sel_scr_rd_addr  = '0;
        sel_done         = 1'b0;
        other_wr         = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cur_layer_q == LW'(i)) begin
                sel_in_rd_addr   = bus.lyr_rd_in_addr[i*IN_ADDR_W +: IN_ADDR_W];
                sel_feat_wr_en   = bus.lyr_feat_wr_en[i];
                sel_feat_wr_addr = bus.lyr_feat_wr_addr[i*FEAT_ADDR_W +: FEAT_ADDR_W];
                sel_feat_wr_data = bus.lyr_feat_wr_data[i*FEAT_WIDTH +: FEAT_WIDTH];
                sel_feat_rd_addr = bus.lyr_feat_rd_addr[i*FEAT_ADDR_W +: FEAT_ADDR_W];
                sel_scr_wr_en    = bus.lyr_scr_wr_en[i];
                sel_scr_wr_addr  = bus.lyr_scr_wr_addr[i*SCR_ADDR_W +: SCR_ADDR_W];
                sel_scr_wr_data  = bus.lyr_scr_wr_data[i*SCR_WIDTH +: SCR_WIDTH];
                sel_scr_rd_addr  = bus.lyr_scr_rd_addr[i*SCR_ADDR_W +: SCR_ADDR_W];
                sel_done         = bus.lyr_done[i];
            end else begin
                other_wr = other_wr | bus.lyr_feat_wr_en[i] | bus.lyr_scr_wr_en[i];
            end
        end
    end

    logic ps_phase, lyr_phase, start_acc;
    logic ps_wr_ok, feat_wr_ok, scr_wr_ok, illegal_evt;

    always_comb begin
        ps_phase    = (state_q == StIdle) || (state_q == StLoad);
        lyr_phase   = (state_q == StRun) || (state_q == StDrain);
        start_acc   = start && ((state_q == StIdle) || (state_q == StDone));
        // Out-of-range writes are silently dropped; only wrong-phase/wrong-layer writes flag
        ps_wr_ok    = !rst && bus.ps_wr_en && ps_phase && (32'(bus.ps_wr_addr) < IN_DEPTH);
        feat_wr_ok  = !rst && sel_feat_wr_en && lyr_phase &&
                      (32'(sel_feat_wr_addr) < FEAT_DEPTH);
        scr_wr_ok   = !rst && sel_scr_wr_en && lyr_phase && (32'(sel_scr_wr_addr) < SCR_DEPTH);
        illegal_evt = (bus.ps_wr_en && !ps_phase) ||
                      (!lyr_phase && ((|bus.lyr_feat_wr_en) || (|bus.lyr_scr_wr_en))) ||
                      other_wr;
    end

    always_comb begin
        state_d       = state_q;
        cur_layer_d   = cur_layer_q;
        layer_start_d = 1'b0;
        illegal_d     = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    cur_layer_d = '0;
                end
            end
            StLoad: begin
                if (ps_load_done) begin
                    state_d       = StRun;
                    layer_start_d = 1'b1;
                end
            end
            StRun: begin
                if (sel_done) state_d = StDrain;
            end
            StDrain: begin
                if (cur_layer_q == LW'(NUM_LAYERS - 1)) begin
                    state_d = StDone;
                end else begin
                    state_d       = StRun;
                    cur_layer_d   = cur_layer_q + LW'(1);
                    layer_start_d = 1'b1;
                end
            end
            StDone: begin
                if (start) begin
                    state_d     = StLoad;
                    cur_layer_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d     = (state_d == StLoad) || (state_d == StRun) || (state_d == StDrain);
        all_done_d = (state_d == StDone);
        if (start_acc)   illegal_d = 1'b0;
        if (illegal_evt) illegal_d = 1'b1;
    end

    // Read path: layer k reads the bank layer k-1 wrote; layer 0 has no previous features
    always_comb begin
        in_rd_d = '0;
        if (32'(sel_in_rd_addr) < IN_DEPTH) in_rd_d = in_mem[sel_in_rd_addr];

        feat_rd_d = '0;
        if ((cur_layer_q != '0) && (32'(sel_feat_rd_addr) < FEAT_DEPTH)) begin
            feat_rd_d = cur_layer_q[0] ? feat_mem0[sel_feat_rd_addr]
                                       : feat_mem1[sel_feat_rd_addr];
        end

        scr_rd_d = '0;
        if (32'(sel_scr_rd_addr) < SCR_DEPTH) scr_rd_d = scr_mem[sel_scr_rd_addr];
`ifdef LMC_SCR_FWD_EN
        if (scr_wr_ok && (sel_scr_wr_addr == sel_scr_rd_addr)) scr_rd_d = sel_scr_wr_data;
`else
        // Read-first: same-address write lands after this read samples the array
`endif
    end

    always_ff @(posedge clk) begin
        if (ps_wr_ok) in_mem[bus.ps_wr_addr] <= bus.ps_wr_data;
        if (feat_wr_ok && !cur_layer_q[0]) feat_mem0[sel_feat_wr_addr] <= sel_feat_wr_data;
        if (feat_wr_ok && cur_layer_q[0])  feat_mem1[sel_feat_wr_addr] <= sel_feat_wr_data;
        if (scr_wr_ok) scr_mem[sel_scr_wr_addr] <= sel_scr_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cur_layer_q   <= '0;
            layer_start_q <= 1'b0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            illegal_q     <= 1'b0;
            in_rd_q       <= '0;
            feat_rd_q     <= '0;
            scr_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            cur_layer_q   <= cur_layer_d;
            layer_start_q <= layer_start_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
            illegal_q     <= illegal_d;
            in_rd_q       <= in_rd_d;
            feat_rd_q     <= feat_rd_d;
            scr_rd_q      <= scr_rd_d;
        end
    end

    assign cur_layer        = cur_layer_q;
    assign layer_start      = layer_start_q;
    assign busy             = busy_q;
    assign all_done         = all_done_q;
    assign illegal_wr       = illegal_q;
    assign bus.in_rd_data   = in_rd_q;
    assign bus.feat_rd_data = feat_rd_q;
    assign bus.scr_rd_data  = scr_rd_q;

endmodule

// File: tb/tb_layer_memory_controller.sv
// Scoreboard bench for layer_memory_controller: stimulus queues expected values tagged with the
// cycle they are due, and a negedge monitor compares them against the DUT outputs.
module tb_layer_memory_controller;
    localparam int unsigned IN_WIDTH    = 19;
    localparam int unsigned IN_DEPTH    = 242101;
    localparam int unsigned FEAT_WIDTH  = 32;
    localparam int unsigned FEAT_DEPTH  = 43328;
    localparam int unsigned SCR_WIDTH   = 201;
    localparam int unsigned SCR_DEPTH   = 13264;
    localparam int unsigned NUM_LAYERS  = 2;
    localparam int unsigned IN_ADDR_W   = $clog2(IN_DEPTH);
    localparam int unsigned FEAT_ADDR_W = $clog2(FEAT_DEPTH);
    localparam int unsigned SCR_ADDR_W  = $clog2(SCR_DEPTH);
    localparam int unsigned LW          = $clog2(NUM_LAYERS);

`ifdef LMC_SCR_FWD_EN
    localparam logic [255:0] ScrSameExp = 256'd3;
`else
    localparam logic [255:0] ScrSameExp = 256'd1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ps_load_done;
    logic [LW-1:0] cur_layer;
    logic          layer_start;
    logic          busy;
    logic          all_done;
    logic          illegal_wr;

    layer_memory_controller_if #(
        .IN_WIDTH(IN_WIDTH), .IN_DEPTH(IN_DEPTH), .FEAT_WIDTH(FEAT_WIDTH),
        .FEAT_DEPTH(FEAT_DEPTH), .SCR_WIDTH(SCR_WIDTH), .SCR_DEPTH(SCR_DEPTH),
        .NUM_LAYERS(NUM_LAYERS)
    ) bus ();

    layer_memory_controller #(
        .IN_WIDTH(IN_WIDTH), .IN_DEPTH(IN_DEPTH), .FEAT_WIDTH(FEAT_WIDTH),
        .FEAT_DEPTH(FEAT_DEPTH), .SCR_WIDTH(SCR_WIDTH), .SCR_DEPTH(SCR_DEPTH),
        .NUM_LAYERS(NUM_LAYERS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ps_load_done (ps_load_done),
        .bus          (bus),
        .cur_layer    (cur_layer),
        .layer_start  (layer_start),
        .busy         (busy),
        .all_done     (all_done),
        .illegal_wr   (illegal_wr)
    );

    always #5 clk = ~clk;

    typedef enum int {
        SigCurLayer, SigLayerStart, SigBusy, SigAllDone, SigIllegal, SigInRd, SigFeatRd, SigScrRd
    } sig_e;

    int unsigned  due_q [$];
    sig_e         sig_q [$];
    logic [255:0] exp_q [$];
    string        tag_q [$];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] actual(input sig_e s);
        logic [255:0] v;
        v = '0;
        case (s)
            SigCurLayer:   v = 256'(cur_layer);
            SigLayerStart: v = 256'(layer_start);
            SigBusy:       v = 256'(busy);
            SigAllDone:    v = 256'(all_done);
            SigIllegal:    v = 256'(illegal_wr);
            SigInRd:       v = 256'(bus.in_rd_data);
            SigFeatRd:     v = 256'(bus.feat_rd_data);
            SigScrRd:      v = 256'(bus.scr_rd_data);
            default:       v = '0;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        for (int i = int'(due_q.size()) - 1; i >= 0; i--) begin
            if (due_q[i] == cyc) begin
                mon_act = actual(sig_q[i]);
                checks++;
                if (mon_act !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", tag_q[i], mon_act, exp_q[i]);
                end
                due_q.delete(i);
                sig_q.delete(i);
                exp_q.delete(i);
                tag_q.delete(i);
            end
        end
    end

    task automatic exp_push(input sig_e s, input logic [255:0] v, input int unsigned d,
                            input string tag);
        due_q.push_back(cyc + d);
        sig_q.push_back(s);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input int unsigned d, input string tag);
        exp_push(SigCurLayer,   256'd0, d, {tag, "_cur_layer"});
        exp_push(SigLayerStart, 256'd0, d, {tag, "_layer_start"});
        exp_push(SigBusy,       256'd0, d, {tag, "_busy"});
        exp_push(SigAllDone,    256'd0, d, {tag, "_all_done"});
        exp_push(SigIllegal,    256'd0, d, {tag, "_illegal"});
        exp_push(SigInRd,       256'd0, d, {tag, "_in_rd"});
        exp_push(SigFeatRd,     256'd0, d, {tag, "_feat_rd"});
        exp_push(SigScrRd,      256'd0, d, {tag, "_scr_rd"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ps_load_done = 1'b0;
        bus.ps_wr_en = 1'b0; bus.ps_wr_addr = '0; bus.ps_wr_data = '0;
        bus.lyr_rd_in_addr = '0; bus.lyr_feat_wr_en = '0; bus.lyr_feat_wr_addr = '0;
        bus.lyr_feat_wr_data = '0; bus.lyr_feat_rd_addr = '0; bus.lyr_scr_wr_en = '0;
        bus.lyr_scr_wr_addr = '0; bus.lyr_scr_wr_data = '0; bus.lyr_scr_rd_addr = '0;
        bus.lyr_done = '0;
        repeat (2) tick();
        all_zero(0, "reset");
        rst = 1'b0;

        // PS load in IDLE, read back through layer 0's input port
        tick();
        bus.ps_wr_en = 1'b1; bus.ps_wr_addr = IN_ADDR_W'(3); bus.ps_wr_data = 19'h5A5A5;
        tick();
        bus.ps_wr_en = 1'b0;
        bus.lyr_rd_in_addr[0 +: IN_ADDR_W] = IN_ADDR_W'(3);
        exp_push(SigInRd, 256'h5A5A5, 1, "ps_load_readback");

        // start together with ps_load_done
        tick();
        start = 1'b1; ps_load_done = 1'b1;
        exp_push(SigBusy,       256'd1, 1, "load_busy");
        exp_push(SigLayerStart, 256'd0, 1, "load_no_pulse");
        exp_push(SigLayerStart, 256'd1, 2, "run_entry_pulse");
        exp_push(SigCurLayer,   256'd0, 2, "run_layer0");
        exp_push(SigBusy,       256'd1, 2, "run_busy");
        tick();
        start = 1'b0;
        tick();
        exp_push(SigLayerStart, 256'd0, 1, "pulse_one_cycle");

        // layer 0 writes features and scratch
        bus.lyr_feat_wr_en[0] = 1'b1;
        bus.lyr_feat_wr_addr[0 +: FEAT_ADDR_W] = FEAT_ADDR_W'(5);
        bus.lyr_feat_wr_data[0 +: FEAT_WIDTH] = 32'hDEADBEEF;
        bus.lyr_feat_rd_addr[0 +: FEAT_ADDR_W] = FEAT_ADDR_W'(5);
        bus.lyr_scr_wr_en[0] = 1'b1;
        bus.lyr_scr_wr_addr[0 +: SCR_ADDR_W] = SCR_ADDR_W'(7);
        bus.lyr_scr_wr_data[0 +: SCR_WIDTH] = SCR_WIDTH'(1);
        exp_push(SigFeatRd, 256'd0, 1, "layer0_feat_rd_zero");
        tick();
        bus.lyr_feat_wr_en = '0;
        bus.lyr_scr_wr_data[0 +: SCR_WIDTH] = SCR_WIDTH'(3);
        bus.lyr_scr_rd_addr[0 +: SCR_ADDR_W] = SCR_ADDR_W'(7);
        exp_push(SigScrRd, ScrSameExp, 1, "scr_same_addr");
        tick();
        bus.lyr_scr_wr_en = '0;
        exp_push(SigScrRd, 256'd3, 1, "scr_after_write");

        // done from the inactive layer must be ignored
        bus.lyr_done = 2'b10;
        exp_push(SigCurLayer,   256'd0, 2, "foreign_done_layer");
        exp_push(SigLayerStart, 256'd0, 2, "foreign_done_pulse");
        tick();
        bus.lyr_done = '0;
        tick();
        bus.lyr_done = 2'b01;
        exp_push(SigBusy,       256'd1, 1, "drain_busy");
        exp_push(SigLayerStart, 256'd0, 1, "drain_no_pulse");
        exp_push(SigCurLayer,   256'd0, 1, "drain_layer0");
        exp_push(SigCurLayer,   256'd1, 2, "run_layer1");
        exp_push(SigLayerStart, 256'd1, 2, "layer1_pulse");
        exp_push(SigLayerStart, 256'd0, 3, "layer1_pulse_end");
        tick();
        bus.lyr_done = '0;
        tick();

        // layer 1 reads layer 0's bank while writing its own
        bus.lyr_feat_rd_addr[0 +: FEAT_ADDR_W] = FEAT_ADDR_W'(9);
        bus.lyr_feat_rd_addr[FEAT_ADDR_W +: FEAT_ADDR_W] = FEAT_ADDR_W'(5);
        bus.lyr_feat_wr_en[1] = 1'b1;
        bus.lyr_feat_wr_addr[FEAT_ADDR_W +: FEAT_ADDR_W] = FEAT_ADDR_W'(5);
        bus.lyr_feat_wr_data[FEAT_WIDTH +: FEAT_WIDTH] = 32'hCAFEF00D;
        bus.lyr_scr_rd_addr[0 +: SCR_ADDR_W] = SCR_ADDR_W'(0);
        bus.lyr_scr_rd_addr[SCR_ADDR_W +: SCR_ADDR_W] = SCR_ADDR_W'(7);
        exp_push(SigFeatRd, 256'hDEADBEEF, 1, "layer1_reads_layer0");
        exp_push(SigScrRd,  256'd3,        1, "layer1_scr_slice");
        tick();
        bus.lyr_feat_wr_en = '0;
        exp_push(SigFeatRd, 256'hDEADBEEF, 1, "pingpong_bank_sep");
        exp_push(SigIllegal, 256'd0, 0, "no_illegal_yet");

        // PS write during RUN is dropped and flagged
        bus.ps_wr_en = 1'b1; bus.ps_wr_addr = IN_ADDR_W'(3); bus.ps_wr_data = 19'h7FFFF;
        bus.lyr_rd_in_addr[IN_ADDR_W +: IN_ADDR_W] = IN_ADDR_W'(3);
        exp_push(SigIllegal, 256'd1, 1, "illegal_ps_in_run");
        tick();
        bus.ps_wr_en = 1'b0;
        exp_push(SigInRd, 256'h5A5A5, 1, "ps_run_write_dropped");
        tick();

        bus.lyr_done = 2'b10;
        exp_push(SigBusy,    256'd1, 1, "drain1_busy");
        exp_push(SigAllDone, 256'd0, 1, "drain1_not_done");
        exp_push(SigAllDone, 256'd1, 2, "all_done");
        exp_push(SigBusy,    256'd0, 2, "done_not_busy");
        exp_push(SigIllegal, 256'd1, 2, "illegal_sticky");
        tick();
        bus.lyr_done = '0;
        repeat (2) tick();
        exp_push(SigAllDone, 256'd1, 0, "all_done_hold");

        // restart from DONE clears all_done and illegal_wr
        start = 1'b1; ps_load_done = 1'b0;
        exp_push(SigAllDone,  256'd0, 1, "restart_clears_done");
        exp_push(SigIllegal,  256'd0, 1, "start_clears_illegal");
        exp_push(SigCurLayer, 256'd0, 1, "restart_layer0");
        exp_push(SigBusy,     256'd1, 1, "restart_busy");
        tick();
        start = 1'b0;
        bus.lyr_scr_wr_en[0] = 1'b1;
        bus.lyr_scr_wr_addr[0 +: SCR_ADDR_W] = SCR_ADDR_W'(7);
        bus.lyr_scr_wr_data[0 +: SCR_WIDTH] = SCR_WIDTH'(8'h55);
        bus.lyr_scr_rd_addr[0 +: SCR_ADDR_W] = SCR_ADDR_W'(7);
        exp_push(SigScrRd,      256'd3, 1, "load_write_not_fwd");
        exp_push(SigIllegal,    256'd1, 1, "illegal_lyr_in_load");
        exp_push(SigLayerStart, 256'd0, 1, "wait_load_done");
        exp_push(SigBusy,       256'd1, 1, "load_wait_busy");
        tick();
        bus.lyr_scr_wr_en = '0;
        exp_push(SigScrRd, 256'd3, 1, "load_write_dropped");
        ps_load_done = 1'b1;
        exp_push(SigLayerStart, 256'd1, 1, "run2_pulse");
        tick();
        bus.lyr_done = 2'b01;
        tick();
        bus.lyr_done = '0;
        tick();
        exp_push(SigCurLayer, 256'd1, 0, "run2_layer1");

        // reset in RUN at layer 1 aborts; banks survive
        rst = 1'b1;
        all_zero(1, "abort");
        tick();
        rst = 1'b0;
        bus.lyr_rd_in_addr[0 +: IN_ADDR_W] = IN_ADDR_W'(3);
        exp_push(SigInRd, 256'h5A5A5, 1, "bank_kept_after_rst");
        tick();

        // write on the inactive layer's slice is dropped and flagged
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_push(SigIllegal,  256'd0, 0, "clean_after_rst");
        exp_push(SigCurLayer, 256'd0, 0, "run3_layer0");
        bus.lyr_feat_wr_en[1] = 1'b1;
        bus.lyr_feat_wr_addr[FEAT_ADDR_W +: FEAT_ADDR_W] = FEAT_ADDR_W'(9);
        bus.lyr_feat_wr_data[FEAT_WIDTH +: FEAT_WIDTH] = 32'h12345678;
        exp_push(SigIllegal, 256'd1, 1, "illegal_other_slice");
        tick();
        bus.lyr_feat_wr_en = '0;
        repeat (3) tick();

        if (due_q.size() != 0) begin
            errors += int'(due_q.size());
            $display("FAIL pending: got %0d unchecked expected 0", due_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
